// File: rtl/piradip_bit_sync_detector.sv
// piradip_bit_sync_detector: bit-serial frame synchroniser (HUNT -> VERIFY -> LOCKED).
// Latency: zero; payload bits pass combinationally from in_* to out_* while locked.
// Backpressure: in_ready follows out_ready in the payload phase and is 1 otherwise.
//
// Ports:
//   clk, rst (async, active-high), resync (sync request to re-hunt)
//   in_valid/in_ready/in_data   : raw bit stream in
//   out_valid/out_ready/out_data: payload bits out, out_align marks bit 0 of each frame
//   locked, sync_miss (1-cycle pulse after a failed periodic check), frame_count
// Optional: define PIRADIP_BIT_SYNC_INVERT_EN to also acquire on ~SYNC_WORD, correct
//   the polarity of all following bits, and expose the polarity flag on `inverted`.
module piradip_bit_sync_detector #(
  parameter int                    SYNC_WIDTH = 32,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 32'hA5A5A5A5,
  parameter int                    FRAME_BITS = 256,
  parameter int                    MAX_ERRORS = 0,
  parameter int                    LOCK_COUNT = 2,
  parameter int                    LOSS_COUNT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resync,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_data,
  output logic        out_align,
  output logic        locked,
  output logic        sync_miss,
  output logic [15:0] frame_count
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
  , output logic      inverted
`endif
);

  localparam int CW = $clog2(FRAME_BITS + SYNC_WIDTH);
  localparam int BW = $clog2(SYNC_WIDTH + 1);
  localparam int HW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_BITS + SYNC_WIDTH - 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [SYNC_WIDTH-1:0] window_q, window_d, window_nxt;
  logic [BW-1:0]         bits_seen_q, bits_seen_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [HW-1:0]         hits_q, hits_d;
  logic [MW-1:0]         misses_q, misses_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic                  sync_miss_q, sync_miss_d;
  logic                  pol, bit_in, match, payload, last, beat;
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
  logic                  inv_q, inv_d, match_inv;
`endif

  function automatic int popcount(input logic [SYNC_WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < SYNC_WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction

  always_comb begin
    pol = 1'b0;
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
    pol = inv_q;
`endif
    // Polarity correction applies to both the sync window and forwarded payload.
    bit_in     = in_data ^ pol;
    window_nxt = {window_q[SYNC_WIDTH-2:0], bit_in};
    match      = popcount(window_nxt ^ SYNC_WORD) <= MAX_ERRORS;
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
    match_inv  = popcount(window_nxt ^ ~SYNC_WORD) <= MAX_ERRORS;
`endif
    payload   = (state_q == LOCKED) && (bit_cnt_q < CW'(FRAME_BITS));
    last      = (bit_cnt_q == LAST_BEAT);
    in_ready  = payload ? out_ready : 1'b1;
    out_valid = payload & in_valid;
    out_data  = payload & bit_in;
    out_align = out_valid && (bit_cnt_q == '0);
    beat      = in_valid & in_ready;
  end

  always_comb begin
    state_d       = state_q;
    window_d      = window_q;
    bits_seen_d   = bits_seen_q;
    bit_cnt_d     = bit_cnt_q;
    hits_d        = hits_q;
    misses_d      = misses_q;
    frame_count_d = frame_count_q;
    sync_miss_d   = 1'b0;
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
    inv_d         = inv_q;
`endif
    if (resync) begin
      // A beat in the same cycle is swallowed: nothing below runs.
      state_d     = HUNT;
      window_d    = '0;
      bits_seen_d = '0;
      bit_cnt_d   = '0;
      hits_d      = '0;
      misses_d    = '0;
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
      inv_d       = 1'b0;
`endif
    end else if (beat) begin
      window_d  = window_nxt;
      bit_cnt_d = last ? '0 : bit_cnt_q + 1'b1;
      case (state_q)
        HUNT: begin
          bit_cnt_d = '0;
          if (bits_seen_q != BW'(SYNC_WIDTH)) bits_seen_d = bits_seen_q + 1'b1;
          // Only a window filled entirely with bits seen since the last hunt start counts.
          if (bits_seen_q >= BW'(SYNC_WIDTH - 1)) begin
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
            if (match || match_inv) begin
              inv_d = !match;
`else
            if (match) begin
`endif
              hits_d   = HW'(1);
              misses_d = '0;
              state_d  = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
            end
          end
        end
        VERIFY: begin
          if (last) begin
            if (match) begin
              hits_d = hits_q + 1'b1;
              if (hits_q == HW'(LOCK_COUNT - 1)) state_d = LOCKED;
            end else begin
              state_d     = HUNT;
              bits_seen_d = '0;
              hits_d      = '0;
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
              inv_d       = 1'b0;
`endif
            end
          end
        end
        LOCKED: begin
          if (bit_cnt_q == CW'(FRAME_BITS - 1)) frame_count_d = frame_count_q + 16'd1;
          if (last) begin
            if (match) begin
              misses_d = '0;
            end else begin
              sync_miss_d = 1'b1;
              if (misses_q == MW'(LOSS_COUNT - 1)) begin
                state_d     = HUNT;
                bits_seen_d = '0;
                hits_d      = '0;
                misses_d    = '0;
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
                inv_d       = 1'b0;
`endif
              end else begin
                // Flywheel: keep forwarding on the established frame phase.
                misses_d = misses_q + 1'b1;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      window_q      <= '0;
      bits_seen_q   <= '0;
      bit_cnt_q     <= '0;
      hits_q        <= '0;
      misses_q      <= '0;
      frame_count_q <= '0;
      sync_miss_q   <= 1'b0;
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
      inv_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      window_q      <= window_d;
      bits_seen_q   <= bits_seen_d;
      bit_cnt_q     <= bit_cnt_d;
      hits_q        <= hits_d;
      misses_q      <= misses_d;
      frame_count_q <= frame_count_d;
      sync_miss_q   <= sync_miss_d;
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
      inv_q         <= inv_d;
`endif
    end
  end

  assign locked      = (state_q == LOCKED);
  assign sync_miss   = sync_miss_q;
  assign frame_count = frame_count_q;
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
  assign inverted    = inv_q;
`endif

endmodule

// File: tb/tb_piradip_bit_sync_detector.sv
module tb_piradip_bit_sync_detector;
  localparam int SW = 32;
  localparam int FB = 64;
  localparam int P  = FB + SW;
  localparam logic [31:0] SYNC = 32'hA5A5A5A5;

  logic clk = 1'b0, rst = 1'b1, resync = 1'b0;
  logic in_valid = 1'b0, in_data = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_data, out_align, locked, sync_miss;
  logic [15:0] frame_count;
  logic t_in_ready, t_out_valid, t_out_data, t_out_align, t_locked, t_sync_miss;
  logic [15:0] t_frame_count;
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
  logic inverted, t_inverted;
`endif

  int n_cmp = 0, n_fail = 0;
  bit stim[$], got_out[$], got_align[$], exp_q[$], m_out[$];
  int n_miss, rise_idx, fall_idx, stall_lo, m_frames, m_miss;
  bit m_locked;

  always #5 clk = ~clk;

  piradip_bit_sync_detector #(.SYNC_WIDTH(SW), .SYNC_WORD(SYNC), .FRAME_BITS(FB),
    .MAX_ERRORS(0), .LOCK_COUNT(2), .LOSS_COUNT(2)) dut (
    .clk(clk), .rst(rst), .resync(resync), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_align(out_align), .locked(locked), .sync_miss(sync_miss), .frame_count(frame_count)
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
    , .inverted(inverted)
`endif
  );

  piradip_bit_sync_detector #(.SYNC_WIDTH(SW), .SYNC_WORD(SYNC), .FRAME_BITS(FB),
    .MAX_ERRORS(1), .LOCK_COUNT(2), .LOSS_COUNT(2)) dut_tol (
    .clk(clk), .rst(rst), .resync(resync), .in_valid(in_valid), .in_ready(t_in_ready),
    .in_data(in_data), .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
    .out_align(t_out_align), .locked(t_locked), .sync_miss(t_sync_miss),
    .frame_count(t_frame_count)
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
    , .inverted(t_inverted)
`endif
  );

  // ---------------- stream building ----------------
  task automatic push_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) stim.push_back(w[i]);
  endtask

  // last_val < 0 leaves the final bit random; otherwise forces it (keeps shifted
  // copies of the sync word from forming across the boundary into the next sync).
  task automatic push_rand(input int n, input int last_val);
    for (int i = 0; i < n; i++) stim.push_back(1'($urandom_range(0, 1)));
    if (n > 0 && last_val >= 0) stim[stim.size()-1] = 1'(last_val);
  endtask

  task automatic set_exp64(input logic [63:0] v);
    exp_q.delete();
    for (int i = 63; i >= 0; i--) exp_q.push_back(v[i]);
  endtask

  function automatic int qdiff();
    int d;
    d = (got_out.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < got_out.size() && i < exp_q.size(); i++)
      if (got_out[i] !== exp_q[i]) d++;
    return d;
  endfunction

  // ---------------- reference model ----------------
  function automatic bit mmatch(input int j);
    logic [31:0] w;
    for (int k = 0; k < SW; k++) w[SW-1-k] = stim[j-SW+1+k];
    return $countones(w ^ SYNC) == 0;
  endfunction

  // Scans the stream by jumping between sync positions: find an acquisition point,
  // then test every P-th bit; locked frames contribute their FB payload bits.
  task automatic model_run();
    int n, pos, p, q, hits, misses;
    bit lk;
    n = stim.size(); pos = SW - 1;
    m_out.delete(); m_frames = 0; m_miss = 0; m_locked = 0;
    while (pos < n) begin
      if (!mmatch(pos)) begin pos++; continue; end
      hits = 1; misses = 0; lk = 0; p = pos;
      while (1) begin
        if (lk) begin
          for (int k = 1; k <= FB; k++) if (p + k < n) m_out.push_back(stim[p+k]);
          if (p + FB < n) m_frames++;
        end
        q = p + P;
        if (q >= n) begin m_locked = lk; return; end
        if (mmatch(q)) begin
          if (lk) misses = 0;
          else begin hits++; if (hits == 2) lk = 1; end
        end else if (lk) begin
          m_miss++; misses++;
          if (misses == 2) begin pos = q + SW; break; end
        end else begin
          pos = q + SW; break;
        end
        p = q;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; resync = 1'b0; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input int gap_pct, input bit rnd_ready, input int stall_at,
                       input int stall_len);
    int idx, cyc, stall_left, limit;
    bit prev_lk, beat, stalled;
    idx = 0; cyc = 0; stall_left = stall_len; limit = stim.size() * 10 + 200;
    prev_lk = locked;
    got_out.delete(); got_align.delete();
    n_miss = 0; rise_idx = -1; fall_idx = -1; stall_lo = 0;
    while (idx < stim.size() && cyc < limit) begin
      @(negedge clk);
      cyc++;
      in_valid  = ($urandom_range(0, 99) >= gap_pct);
      in_data   = stim[idx];
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      stalled   = 1'b0;
      if (stall_at >= 0 && got_out.size() == stall_at && stall_left > 0) begin
        out_ready = 1'b0; stall_left--; stalled = 1'b1;
      end
      #1;
      if (stalled && !in_ready) stall_lo++;
      if (out_valid && out_ready) begin
        got_out.push_back(out_data); got_align.push_back(out_align);
      end
      beat = in_valid && in_ready;
      @(posedge clk); #1;
      if (sync_miss) n_miss++;
      if (beat) begin
        if (locked && !prev_lk && rise_idx < 0) rise_idx = idx;
        if (!locked && prev_lk && fall_idx < 0) fall_idx = idx;
        idx++;
      end
      prev_lk = locked;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (idx < stim.size()) begin
      n_fail++; $display("FAIL drive_timeout: consumed %0d bits required %0d", idx, stim.size());
    end
  endtask

  // Standard acquisition prefix: 13 random bits, sync, filler payload, sync.
  task automatic build_acquire();
    stim.delete();
    push_rand(13, 0);
    push_word(SYNC); push_word(32'hCCCCCCCC); push_word(32'hDDDDDDDD); push_word(SYNC);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_data = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_cmp++; if ({out_valid, out_data, out_align, locked, sync_miss} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b required 00000", {out_valid, out_data, out_align, locked, sync_miss}); end
    n_cmp++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d required 0", frame_count); end
    @(negedge clk); rst = 1'b0; in_data = 1'b0;
  endtask

  task automatic test_acquisition();
    int n_al;
    do_reset();
    build_acquire();
    push_word(32'h12345678); push_word(32'h9ABCDEF0);
    drive(0, 0, -1, 0);
    n_cmp++; if (rise_idx !== 140) begin n_fail++; $display("FAIL acq_lock_beat: got %0d required 140", rise_idx); end
    set_exp64(64'h123456789ABCDEF0);
    n_cmp++; if (qdiff() !== 0) begin n_fail++; $display("FAIL acq_payload: got %0d bits (%0d diffs) required 64", got_out.size(), qdiff()); end
    n_al = 0;
    foreach (got_align[i]) n_al += int'(got_align[i]);
    n_cmp++; if (n_al !== 1 || got_align.size() == 0 || got_align[0] !== 1'b1) begin
      n_fail++; $display("FAIL acq_align: got %0d aligns required 1 on bit 0", n_al); end
    n_cmp++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL acq_frame_count: got %0d required 1", frame_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    build_acquire();
    push_word(32'h12345678); push_word(32'h9ABCDEF0); push_word(SYNC);
    drive(0, 0, 20, 10);
    n_cmp++; if (stall_lo !== 10) begin n_fail++; $display("FAIL bp_in_ready_low: got %0d cycles required 10", stall_lo); end
    set_exp64(64'h123456789ABCDEF0);
    n_cmp++; if (qdiff() !== 0) begin n_fail++; $display("FAIL bp_payload: got %0d bits (%0d diffs) required 64", got_out.size(), qdiff()); end
    n_cmp++; if (n_miss !== 0) begin n_fail++; $display("FAIL bp_sync_miss: got %0d required 0", n_miss); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL bp_locked: got %b required 1", locked); end
  endtask

  task automatic test_flywheel_loss();
    do_reset();
    build_acquire();
    push_rand(64, 0); push_word(32'hA5A5A5A4);
    push_rand(64, 0); push_word(32'hA5A5A5A4);
    push_rand(64, 0); push_word(SYNC); push_rand(64, -1);
    drive(0, 0, -1, 0);
    model_run();
    n_cmp++; if (n_miss !== 2) begin n_fail++; $display("FAIL fly_sync_miss: got %0d required 2", n_miss); end
    n_cmp++; if (fall_idx !== 332) begin n_fail++; $display("FAIL fly_unlock_beat: got %0d required 332", fall_idx); end
    exp_q = m_out;
    n_cmp++; if (got_out.size() !== 128 || qdiff() !== 0) begin
      n_fail++; $display("FAIL fly_payload: got %0d bits (%0d diffs) required 128", got_out.size(), qdiff()); end
    n_cmp++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL fly_frame_count: got %0d required 2", frame_count); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL fly_locked_end: got %b required 0", locked); end
  endtask

  task automatic test_tolerance();
    do_reset();
    stim.delete();
    for (int i = 0; i < 13; i++) stim.push_back(1'b0);
    push_word(32'hA5A5A5A4); push_rand(64, 0); push_word(SYNC); push_rand(64, -1);
    drive(0, 0, -1, 0);
    n_cmp++; if (t_locked !== 1'b1) begin n_fail++; $display("FAIL tol_one_err_lock: got %b required 1", t_locked); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL tol_exact_no_lock: got %b required 0", locked); end
    do_reset();
    stim.delete();
    for (int i = 0; i < 13; i++) stim.push_back(1'b0);
    push_word(32'hA5A5A5A6); push_rand(64, 0); push_word(32'hA5A5A5A6); push_rand(64, -1);
    drive(0, 0, -1, 0);
    n_cmp++; if (t_locked !== 1'b0) begin n_fail++; $display("FAIL tol_two_err_no_lock: got %b required 0", t_locked); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    build_acquire();
    push_rand(64, 0); push_word(SYNC); push_rand(20, -1);
    drive(0, 0, -1, 0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || frame_count !== 16'd1) begin
      n_fail++; $display("FAIL rst_pre_state: got valid=%b frames=%0d required 1/1", out_valid, frame_count); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({out_valid, locked} !== 2'b00 || frame_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_async: got valid=%b locked=%b frames=%0d required 0/0/0", out_valid, locked, frame_count); end
    @(negedge clk);
    in_valid = 1'b0; in_data = 1'b0; rst = 1'b0;
  endtask

  task automatic test_resync();
    logic [63:0] pay;
    do_reset();
    build_acquire();
    push_rand(64, 0); push_word(SYNC); push_rand(30, -1);
    drive(0, 0, -1, 0);
    @(negedge clk);
    resync = 1'b1; in_valid = 1'b1; in_data = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL resync_hunt: got locked=%b required 0", locked); end
    n_cmp++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL resync_frames_kept: got %0d required 1", frame_count); end
    @(negedge clk);
    resync = 1'b0; in_valid = 1'b0;
    pay = {32'($urandom), 32'($urandom)};
    stim.delete();
    push_word(SYNC); push_rand(64, 0); push_word(SYNC); push_word(pay[63:32]); push_word(pay[31:0]);
    drive(0, 0, -1, 0);
    n_cmp++; if (rise_idx !== 127) begin n_fail++; $display("FAIL resync_relock_beat: got %0d required 127", rise_idx); end
    set_exp64(pay);
    n_cmp++; if (qdiff() !== 0) begin n_fail++; $display("FAIL resync_payload: got %0d bits (%0d diffs) required 64", got_out.size(), qdiff()); end
    n_cmp++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL resync_frame_count: got %0d required 2", frame_count); end
  endtask

  task automatic test_random();
    int r, al_bad;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      stim.delete();
      push_rand($urandom_range(0, 40), 0);
      for (int f = 0; f < 8; f++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      push_word(SYNC);
        else if (r < 8) push_word(SYNC ^ (32'd1 << $urandom_range(0, 31)));
        else            push_word(32'($urandom));
        push_rand(FB, 0);
      end
      drive(25, 1, -1, 0);
      model_run();
      exp_q = m_out;
      n_cmp++; if (qdiff() !== 0) begin n_fail++; $display("FAIL rnd%0d_payload: got %0d bits (%0d diffs) required %0d", it, got_out.size(), qdiff(), m_out.size()); end
      al_bad = 0;
      foreach (got_align[i]) if (got_align[i] !== ((i % FB) == 0)) al_bad++;
      n_cmp++; if (al_bad !== 0) begin n_fail++; $display("FAIL rnd%0d_align: got %0d misplaced required 0", it, al_bad); end
      n_cmp++; if (frame_count !== 16'(m_frames)) begin n_fail++; $display("FAIL rnd%0d_frames: got %0d required %0d", it, frame_count, m_frames); end
      n_cmp++; if (n_miss !== m_miss) begin n_fail++; $display("FAIL rnd%0d_sync_miss: got %0d required %0d", it, n_miss, m_miss); end
      n_cmp++; if (locked !== m_locked) begin n_fail++; $display("FAIL rnd%0d_locked: got %b required %b", it, locked, m_locked); end
    end
  endtask

`ifdef PIRADIP_BIT_SYNC_INVERT_EN
  task automatic test_inversion();
    logic [63:0] pay;
    do_reset();
    pay = 64'h123456789ABCDEF0;
    stim.delete();
    push_rand(13, 1);
    push_word(~SYNC); push_rand(64, 1); push_word(~SYNC);
    push_word(~pay[63:32]); push_word(~pay[31:0]);
    drive(0, 0, -1, 0);
    n_cmp++; if ({inverted, locked} !== 2'b11) begin n_fail++; $display("FAIL inv_state: got inverted=%b locked=%b required 1/1", inverted, locked); end
    set_exp64(pay);
    n_cmp++; if (qdiff() !== 0) begin n_fail++; $display("FAIL inv_payload: got %0d bits (%0d diffs) required 64", got_out.size(), qdiff()); end
  endtask
`endif

  initial begin
    test_reset();
    test_acquisition();
    test_backpressure();
    test_flywheel_loss();
    test_tolerance();
    test_reset_mid();
    test_resync();
    test_random();
`ifdef PIRADIP_BIT_SYNC_INVERT_EN
    test_inversion();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
